// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions and the
// operand-fetch state encoding used by decode, register file and control.
package cpu_pkg;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 6;
    localparam int RS2_HI = 5;
    localparam int RS2_LO = 3;

    // 0x0-0x7 are R-type ALU operations; only the upper opcodes are named
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LW   = 4'h9;
    localparam logic [3:0] OP_SW   = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BNE  = 4'hC;
    localparam logic [3:0] OP_LUI  = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2
    } state_t;

    function automatic logic is_rtype(input logic [3:0] op);
        return !op[3];
    endfunction

endpackage

// File: rtl/operand_fetch_imm_gen.sv
// Immediate decoder: derives the immediate value and the use-immediate flag
// from the opcode and raw instruction bits.
module imm_gen
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] imm,
    output logic              use_imm
);

    logic signed [5:0]  off6;
    logic signed [11:0] off12;

    assign off6  = instr[5:0];
    assign off12 = instr[11:0];

    always_comb begin
        imm     = '0;
        use_imm = 1'b0;
        case (instr[OP_HI:OP_LO])
            OP_ADDI, OP_LW: begin
                imm     = DATA_W'(off6);
                use_imm = 1'b1;
            end
            // Stores and branches carry an offset but execute still needs opb
            OP_SW, OP_BEQ, OP_BNE: begin
                imm = DATA_W'(off6);
            end
            OP_LUI: begin
                imm     = {instr[8:0], 7'b0};
                use_imm = 1'b1;
            end
            OP_JMP: begin
                imm     = DATA_W'(off12);
                use_imm = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: holds the instruction, drives register-file
// reads, latches forwarded operands and hands a bundle to execute.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [DATA_W-1:0] instr,
    output logic [REG_AW-1:0] reg_src1,
    output logic [REG_AW-1:0] reg_src2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [3:0]        opcode,
    output logic [REG_AW-1:0] rd,
    output logic [DATA_W-1:0] opa,
    output logic [DATA_W-1:0] opb,
    output logic [DATA_W-1:0] imm,
    output logic              use_imm,
    output logic              reg_we
);

    state_t            state, state_next;
    logic [DATA_W-1:0] ir;
    logic [3:0]        ir_op;
    logic              accept;
    logic [REG_AW-1:0] src1, src2, dst;
    logic              writes;
    logic [DATA_W-1:0] imm_dec;
    logic              use_imm_dec;
    logic [DATA_W-1:0] fwd1, fwd2;

    function automatic logic [DATA_W-1:0] forward(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] rdata,
        input logic              en,
        input logic [REG_AW-1:0] dst_wb,
        input logic [DATA_W-1:0] data_wb
    );
        if (src == '0)
            return '0;
        if (en && dst_wb == src)
            return data_wb;
        return rdata;
    endfunction

    assign ir_op       = ir[OP_HI:OP_LO];
    assign accept      = (state == IDLE) && instr_valid && !flush;
    assign instr_ready = (state == IDLE) && !flush;
    assign op_valid    = (state == VALID);
    assign reg_src1    = src1;
    assign reg_src2    = src2;

    always_comb begin
        src1   = '0;
        src2   = '0;
        dst    = '0;
        writes = 1'b0;
        if (is_rtype(ir_op)) begin
            src1   = ir[RS1_HI:RS1_LO];
            src2   = ir[RS2_HI:RS2_LO];
            dst    = ir[RD_HI:RD_LO];
            writes = 1'b1;
        end else begin
            case (ir_op)
                OP_ADDI, OP_LW: begin
                    src1   = ir[RS1_HI:RS1_LO];
                    dst    = ir[RD_HI:RD_LO];
                    writes = 1'b1;
                end
                // rd field names the store data / second compare register here
                OP_SW, OP_BEQ, OP_BNE: begin
                    src1 = ir[RS1_HI:RS1_LO];
                    src2 = ir[RD_HI:RD_LO];
                end
                OP_LUI: begin
                    dst    = ir[RD_HI:RD_LO];
                    writes = 1'b1;
                end
                default: ;
            endcase
        end
    end

    imm_gen #(
        .DATA_W(DATA_W)
    ) u_imm_gen (
        .instr  (ir),
        .imm    (imm_dec),
        .use_imm(use_imm_dec)
    );

    assign fwd1 = forward(src1, read_data1, wb_en, wb_dst, wb_data);
    assign fwd2 = forward(src2, read_data2, wb_en, wb_dst, wb_data);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (instr_valid) state_next = READ;
            READ:    state_next = VALID;
            VALID:   if (op_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ir <= '0;
        else if (accept)
            ir <= instr;
    end

    // Bundle is captured once, at the end of READ, so it stays put under backpressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode  <= '0;
            rd      <= '0;
            opa     <= '0;
            opb     <= '0;
            imm     <= '0;
            use_imm <= 1'b0;
            reg_we  <= 1'b0;
        end else if (state == READ && !flush) begin
            opcode  <= ir_op;
            rd      <= dst;
            opa     <= fwd1;
            opb     <= fwd2;
            imm     <= imm_dec;
            use_imm <= use_imm_dec;
            reg_we  <= writes;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed and randomized instructions checked every
// cycle against a behavioural model of the stage.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset, flush, instr_valid, instr_ready;
    logic [15:0] instr;
    logic [2:0]  reg_src1, reg_src2;
    logic [15:0] read_data1, read_data2;
    logic        wb_en;
    logic [2:0]  wb_dst;
    logic [15:0] wb_data;
    logic        op_valid, op_ready;
    logic [3:0]  opcode;
    logic [2:0]  rd;
    logic [15:0] opa, opb, imm;
    logic        use_imm, reg_we;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .reset(reset), .flush(flush),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .reg_src1(reg_src1), .reg_src2(reg_src2),
        .read_data1(read_data1), .read_data2(read_data2),
        .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data),
        .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .rd(rd), .opa(opa), .opb(opb), .imm(imm),
        .use_imm(use_imm), .reg_we(reg_we)
    );

    // Register file environment; R0 reads garbage so the stage must force zero itself
    logic [15:0] rf [8];
    assign read_data1 = rf[reg_src1];
    assign read_data2 = rf[reg_src2];

    int n_checks = 0;
    int n_fail   = 0;

    function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct packed {
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [2:0]  rd;
        logic        we;
        logic        ui;
        logic [15:0] imm;
    } dec_t;

    function automatic logic [15:0] sext(input logic [15:0] v, input int bits);
        if (v[bits-1])
            return v - 16'(1 << bits);
        return v;
    endfunction

    function automatic dec_t decode(input logic [15:0] w);
        dec_t d;
        int   op;
        d  = '0;
        op = int'(w[15:12]);
        if (op <= 7) begin
            d.s1 = w[8:6]; d.s2 = w[5:3]; d.rd = w[11:9]; d.we = 1'b1;
        end else if (op == 8 || op == 9) begin
            d.s1 = w[8:6]; d.rd = w[11:9]; d.we = 1'b1; d.ui = 1'b1;
            d.imm = sext(16'(w[5:0]), 6);
        end else if (op >= 10 && op <= 12) begin
            d.s1 = w[8:6]; d.s2 = w[11:9];
            d.imm = sext(16'(w[5:0]), 6);
        end else if (op == 13) begin
            d.rd = w[11:9]; d.we = 1'b1; d.ui = 1'b1;
            d.imm = 16'(w[8:0]) * 16'd128;
        end else if (op == 14) begin
            d.ui = 1'b1;
            d.imm = sext(16'(w[11:0]), 12);
        end
        return d;
    endfunction

    function automatic logic [15:0] fwd(input logic [2:0] s);
        if (s == 3'd0) return 16'd0;
        if (wb_en && wb_dst == s) return wb_data;
        return rf[s];
    endfunction

    // Model: 0 = waiting for instruction, 1 = reading registers, 2 = offering bundle
    int          m_state;
    logic [15:0] m_ir, m_a, m_b, m_imm;
    logic [3:0]  m_opc;
    logic [2:0]  m_rd;
    logic        m_ui, m_we;
    dec_t        m_d;

    always_comb m_d = decode(m_ir);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= 0; m_ir <= '0; m_opc <= '0; m_rd <= '0;
            m_a <= '0; m_b <= '0; m_imm <= '0; m_ui <= 1'b0; m_we <= 1'b0;
        end else if (flush) begin
            m_state <= 0;
        end else if (m_state == 0) begin
            if (instr_valid) begin
                m_ir    <= instr;
                m_state <= 1;
            end
        end else if (m_state == 1) begin
            m_opc   <= m_ir[15:12];
            m_rd    <= m_d.rd;
            m_we    <= m_d.we;
            m_ui    <= m_d.ui;
            m_imm   <= m_d.imm;
            m_a     <= fwd(m_d.s1);
            m_b     <= fwd(m_d.s2);
            m_state <= 2;
        end else if (op_ready) begin
            m_state <= 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("instr_ready", instr_ready, (m_state == 0) && !flush);
            check("op_valid",    op_valid,    m_state == 2);
            check("reg_src1",    reg_src1,    m_d.s1);
            check("reg_src2",    reg_src2,    m_d.s2);
            check("opcode",      opcode,      m_opc);
            check("rd",          rd,          m_rd);
            check("opa",         opa,         m_a);
            check("opb",         opb,         m_b);
            check("imm",         imm,         m_imm);
            check("use_imm",     use_imm,     m_ui);
            check("reg_we",      reg_we,      m_we);
        end
    end

    logic [2:0]  cap_src1, cap_src2, cap_rd;
    logic [15:0] cap_opa, cap_opb, cap_imm;
    logic        cap_valid, cap_ui, cap_we;

    task automatic send(input logic [15:0] w, input int stall,
                        input logic fen, input logic [2:0] fdst, input logic [15:0] fdata);
        int t = 0;
        while (!instr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("accept_timeout", 1, 0);
        #1 instr_valid = 1'b1; instr = w; op_ready = 1'b0;
        wb_en = 1'($urandom); wb_dst = 3'($urandom); wb_data = 16'($urandom);
        @(negedge clk);
        cap_src1 = reg_src1; cap_src2 = reg_src2;
        #1 instr_valid = 1'($urandom); instr = 16'($urandom);
        wb_en = fen; wb_dst = fdst; wb_data = fdata;
        @(negedge clk);
        cap_valid = op_valid; cap_opa = opa; cap_opb = opb; cap_imm = imm;
        cap_rd = rd; cap_ui = use_imm; cap_we = reg_we;
        #1 instr_valid = 1'b1; instr = 16'($urandom);
        wb_en = 1'($urandom); wb_dst = 3'($urandom); wb_data = 16'($urandom);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            #1 wb_en = 1'($urandom); wb_dst = 3'($urandom); wb_data = 16'($urandom);
        end
        op_ready = 1'b1;
        @(negedge clk);
        #1 op_ready = 1'b0; instr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; instr_valid = 1'b0; instr = '0; op_ready = 1'b0;
        wb_en = 1'b0; wb_dst = '0; wb_data = '0;
        rf[0] = 16'hDEAD;
        for (int i = 1; i < 8; i++) rf[i] = 16'($urandom);
        rf[2] = 16'h1234;
        rf[3] = 16'h0F0F;

        // Model pinned to hand-decoded encodings
        check("model_addi_imm", decode(16'h897F).imm, 16'hFFFF);
        check("model_lui_imm",  decode(16'hD3FF).imm, 16'hFF80);
        check("model_jmp_imm",  decode(16'hE800).imm, 16'hF800);
        check("model_sw_src2",  decode(16'hA7C3).s2,  3'd3);

        repeat (2) @(negedge clk);
        check("rst_op_valid", op_valid, 1'b0);
        check("rst_opa",      opa,      16'h0);
        check("rst_reg_src1", reg_src1, 3'd0);
        check("rst_reg_we",   reg_we,   1'b0);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_instr_ready", instr_ready, 1'b1);

        send(16'h0298, 0, 1'b0, 3'd0, 16'h0);
        check("add_src1", cap_src1, 3'd2);
        check("add_src2", cap_src2, 3'd3);
        check("add_valid", cap_valid, 1'b1);
        check("add_opa", cap_opa, 16'h1234);
        check("add_opb", cap_opb, 16'h0F0F);
        check("add_rd", cap_rd, 3'd1);
        check("add_we", cap_we, 1'b1);

        send(16'h897F, 0, 1'b0, 3'd0, 16'h0);
        check("addi_imm", cap_imm, 16'hFFFF);
        check("addi_ui", cap_ui, 1'b1);
        check("addi_opb", cap_opb, 16'h0);

        send(16'hD3FF, 0, 1'b0, 3'd0, 16'h0);
        check("lui_imm", cap_imm, 16'hFF80);
        send(16'hE800, 0, 1'b0, 3'd0, 16'h0);
        check("jmp_imm", cap_imm, 16'hF800);

        send(16'h0298, 0, 1'b1, 3'd2, 16'hBEEF);
        check("fwd_opa", cap_opa, 16'hBEEF);
        send(16'h0218, 0, 1'b1, 3'd0, 16'hBEEF);
        check("fwd_r0_opa", cap_opa, 16'h0);

        send(16'h0298, 5, 1'b0, 3'd0, 16'h0);

        send(16'hA7C3, 0, 1'b0, 3'd0, 16'h0);
        check("sw_src1", cap_src1, 3'd7);
        check("sw_src2", cap_src2, 3'd3);
        check("sw_we", cap_we, 1'b0);
        check("sw_rd", cap_rd, 3'd0);
        check("sw_ui", cap_ui, 1'b0);
        check("sw_imm", cap_imm, 16'h0003);

        // Flush while the bundle is offered; a simultaneous instr_valid must be dropped
        @(negedge clk);
        #1 instr_valid = 1'b1; instr = 16'h0298;
        @(negedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        check("flush_pre_valid", op_valid, 1'b1);
        #1 flush = 1'b1; instr_valid = 1'b1; instr = 16'h897F;
        @(negedge clk);
        check("flush_op_valid", op_valid, 1'b0);
        @(negedge clk);
        #1 flush = 1'b0; instr_valid = 1'b0;
        @(negedge clk);
        check("flush_instr_ready", instr_ready, 1'b1);
        check("flush_no_bundle", op_valid, 1'b0);

        // Asynchronous reset during READ
        #1 instr_valid = 1'b1; instr = 16'h897F;
        @(negedge clk);
        #1 instr_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("areset_op_valid", op_valid, 1'b0);
        check("areset_opa", opa, 16'h0);
        check("areset_src1", reg_src1, 3'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("areset_no_bundle", op_valid, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rf[$urandom_range(1, 7)] = 16'($urandom);
            send(16'($urandom), $urandom_range(0, 3), 1'($urandom), 3'($urandom), 16'($urandom));
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
